// File: rtl/uart_io_pkg.sv
// Shared definitions for the memory-mapped UART: register map, STATUS bit
// positions and the transmitter/receiver state encodings.
package uart_io_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;

  localparam int unsigned ST_TX_FULL     = 0;
  localparam int unsigned ST_TX_EMPTY    = 1;
  localparam int unsigned ST_RX_VALID    = 2;
  localparam int unsigned ST_RX_FULL     = 3;
  localparam int unsigned ST_RX_OVERRUN  = 4;
  localparam int unsigned ST_FRAME_ERR   = 5;
  localparam int unsigned ST_TX_BUSY     = 6;
  localparam int unsigned ST_TX_OVERFLOW = 7;

  localparam int unsigned CTRL_TX_EN = 0;
  localparam int unsigned CTRL_RX_EN = 1;

  typedef enum logic [1:0] {
    TxIdle,
    TxStart,
    TxData,
    TxStop
  } tx_state_e;

  // RxBreak holds after a bad stop bit until the line returns high.
  typedef enum logic [2:0] {
    RxIdle,
    RxStart,
    RxData,
    RxStop,
    RxBreak
  } rx_state_e;

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO; the head is a combinational read of storage.
// A pop on empty is ignored, and a push on full only succeeds with a same-cycle pop.
module uart_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CntW'(DEPTH));
  assign count_o = count_q;
  assign rdata_o = mem_q[rptr_q];

  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + PtrW'(1);
      if (do_pop)  rptr_q <= rptr_q + PtrW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/uart_io_ctrl.sv
// Memory-mapped 8N1 UART: DATA/STATUS/CTRL registers, TX and RX FIFOs,
// and the inline transmit and receive state machines.
module uart_io_ctrl
  import uart_io_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 234,
  parameter int unsigned FIFO_DEPTH   = 16
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [31:0] IO_memAddr_i,
  input  logic [31:0] IO_memWData_i,
  input  logic        IO_memWr_i,
  input  logic        IO_memRd_i,
  output logic [31:0] IO_memRData_o,
  input  logic        rxd_i,
  output logic        txd_o
);

  localparam int unsigned CntW  = $clog2(CLKS_PER_BIT);
  localparam int unsigned FCntW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] HalfLast = CntW'(CLKS_PER_BIT / 2 - 1);

  logic [1:0] reg_sel;
  logic       wr_data, wr_status, wr_ctrl, rx_pop;

  assign reg_sel   = IO_memAddr_i[3:2];
  assign wr_data   = IO_memWr_i & (reg_sel == REG_DATA);
  assign wr_status = IO_memWr_i & (reg_sel == REG_STATUS);
  assign wr_ctrl   = IO_memWr_i & (reg_sel == REG_CTRL);
  assign rx_pop    = IO_memRd_i & (reg_sel == REG_DATA);

  logic             tx_pop, tx_full, tx_empty;
  logic [7:0]       tx_head;
  logic [FCntW-1:0] tx_count;
  logic             rx_push, rx_full, rx_empty;
  logic [7:0]       rx_head, rx_shift_q;
  logic [FCntW-1:0] rx_count;

  uart_fifo #(
    .WIDTH(8),
    .DEPTH(FIFO_DEPTH)
  ) u_tx_fifo (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .push_i (wr_data),
    .wdata_i(IO_memWData_i[7:0]),
    .pop_i  (tx_pop),
    .rdata_o(tx_head),
    .full_o (tx_full),
    .empty_o(tx_empty),
    .count_o(tx_count)
  );

  uart_fifo #(
    .WIDTH(8),
    .DEPTH(FIFO_DEPTH)
  ) u_rx_fifo (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .push_i (rx_push),
    .wdata_i(rx_shift_q),
    .pop_i  (rx_pop),
    .rdata_o(rx_head),
    .full_o (rx_full),
    .empty_o(rx_empty),
    .count_o(rx_count)
  );

  // Control and sticky flags
  logic tx_en_q, rx_en_q;
  logic tx_overflow_q, rx_overrun_q, frame_err_q;
  logic tx_overflow_d, rx_overrun_d, frame_err_d;
  logic tx_overflow_set, rx_overrun_set, frame_err_set;

  assign tx_overflow_set = wr_data & tx_full & ~tx_pop;
  assign rx_overrun_set  = rx_push & rx_full & ~rx_pop;

  // Set wins over a same-cycle W1C clear.
  always_comb begin
    tx_overflow_d = (tx_overflow_q & ~(wr_status & IO_memWData_i[ST_TX_OVERFLOW]))
                    | tx_overflow_set;
    rx_overrun_d  = (rx_overrun_q & ~(wr_status & IO_memWData_i[ST_RX_OVERRUN]))
                    | rx_overrun_set;
    frame_err_d   = (frame_err_q & ~(wr_status & IO_memWData_i[ST_FRAME_ERR]))
                    | frame_err_set;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      tx_en_q       <= 1'b1;
      rx_en_q       <= 1'b1;
      tx_overflow_q <= 1'b0;
      rx_overrun_q  <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        tx_en_q <= IO_memWData_i[CTRL_TX_EN];
        rx_en_q <= IO_memWData_i[CTRL_RX_EN];
      end
      tx_overflow_q <= tx_overflow_d;
      rx_overrun_q  <= rx_overrun_d;
      frame_err_q   <= frame_err_d;
    end
  end

  // Transmitter
  tx_state_e       tx_state_q;
  logic [CntW-1:0] tx_cnt_q;
  logic [2:0]      tx_bit_q;
  logic [7:0]      tx_shift_q;
  logic            txd_q;
  logic            tx_bit_end;

  assign tx_bit_end = (tx_cnt_q == BitLast);
  // Popping at the end of the stop bit gives back-to-back frames with no gap.
  assign tx_pop = tx_en_q & ~tx_empty &
                  ((tx_state_q == TxIdle) | ((tx_state_q == TxStop) & tx_bit_end));
  assign txd_o  = txd_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      tx_state_q <= TxIdle;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      txd_q      <= 1'b1;
    end else begin
      case (tx_state_q)
        TxIdle: begin
          if (tx_pop) begin
            tx_state_q <= TxStart;
            tx_shift_q <= tx_head;
            tx_cnt_q   <= '0;
            txd_q      <= 1'b0;
          end
        end
        TxStart: begin
          if (tx_bit_end) begin
            tx_state_q <= TxData;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            txd_q      <= tx_shift_q[0];
          end else begin
            tx_cnt_q <= tx_cnt_q + CntW'(1);
          end
        end
        TxData: begin
          if (tx_bit_end) begin
            tx_cnt_q <= '0;
            if (tx_bit_q == 3'd7) begin
              tx_state_q <= TxStop;
              txd_q      <= 1'b1;
            end else begin
              tx_bit_q <= tx_bit_q + 3'd1;
              txd_q    <= tx_shift_q[tx_bit_q + 3'd1];
            end
          end else begin
            tx_cnt_q <= tx_cnt_q + CntW'(1);
          end
        end
        TxStop: begin
          if (tx_bit_end) begin
            tx_cnt_q <= '0;
            if (tx_pop) begin
              tx_state_q <= TxStart;
              tx_shift_q <= tx_head;
              txd_q      <= 1'b0;
            end else begin
              tx_state_q <= TxIdle;
            end
          end else begin
            tx_cnt_q <= tx_cnt_q + CntW'(1);
          end
        end
        default: tx_state_q <= TxIdle;
      endcase
    end
  end

  // Receiver
  logic            rx_s1_q, rx_s2_q;
  rx_state_e       rx_state_q;
  logic [CntW-1:0] rx_cnt_q;
  logic [2:0]      rx_bit_q;
  logic            rx_bit_end, rx_half;

  assign rx_bit_end    = (rx_cnt_q == BitLast);
  assign rx_half       = (rx_cnt_q == HalfLast);
  assign rx_push       = rx_en_q & (rx_state_q == RxStop) & rx_bit_end & rx_s2_q;
  assign frame_err_set = rx_en_q & (rx_state_q == RxStop) & rx_bit_end & ~rx_s2_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rx_s1_q <= 1'b1;
      rx_s2_q <= 1'b1;
    end else begin
      rx_s1_q <= rxd_i;
      rx_s2_q <= rx_s1_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rx_state_q <= RxIdle;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
    end else if (!rx_en_q) begin
      rx_state_q <= RxIdle;
    end else begin
      case (rx_state_q)
        RxIdle: begin
          if (!rx_s2_q) begin
            rx_state_q <= RxStart;
            rx_cnt_q   <= '0;
          end
        end
        RxStart: begin
          if (rx_half) begin
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_state_q <= rx_s2_q ? RxIdle : RxData;
          end else begin
            rx_cnt_q <= rx_cnt_q + CntW'(1);
          end
        end
        RxData: begin
          if (rx_bit_end) begin
            rx_cnt_q   <= '0;
            rx_shift_q <= {rx_s2_q, rx_shift_q[7:1]};
            if (rx_bit_q == 3'd7) rx_state_q <= RxStop;
            else                  rx_bit_q   <= rx_bit_q + 3'd1;
          end else begin
            rx_cnt_q <= rx_cnt_q + CntW'(1);
          end
        end
        RxStop: begin
          if (rx_bit_end) begin
            rx_cnt_q   <= '0;
            rx_state_q <= rx_s2_q ? RxIdle : RxBreak;
          end else begin
            rx_cnt_q <= rx_cnt_q + CntW'(1);
          end
        end
        RxBreak: begin
          if (rx_s2_q) rx_state_q <= RxIdle;
        end
        default: rx_state_q <= RxIdle;
      endcase
    end
  end

  // Register read path
  logic [7:0] status;

  always_comb begin
    status                 = '0;
    status[ST_TX_FULL]     = tx_full;
    status[ST_TX_EMPTY]    = tx_empty;
    status[ST_RX_VALID]    = ~rx_empty;
    status[ST_RX_FULL]     = rx_full;
    status[ST_RX_OVERRUN]  = rx_overrun_q;
    status[ST_FRAME_ERR]   = frame_err_q;
    status[ST_TX_BUSY]     = (tx_state_q != TxIdle);
    status[ST_TX_OVERFLOW] = tx_overflow_q;
  end

  always_comb begin
    IO_memRData_o = '0;
    case (reg_sel)
      REG_DATA:   IO_memRData_o = {24'b0, (rx_empty ? 8'h00 : rx_head)};
      REG_STATUS: IO_memRData_o = {24'b0, status};
      REG_CTRL:   IO_memRData_o = {30'b0, rx_en_q, tx_en_q};
      default:    IO_memRData_o = '0;
    endcase
  end

  logic unused_bits;
  assign unused_bits = ^{IO_memAddr_i[31:4], IO_memAddr_i[1:0], IO_memWData_i[31:8],
                         IO_memWData_i[6], IO_memWData_i[3:2], tx_count, rx_count};

endmodule

// File: tb/tb_uart_io_ctrl.sv
// Randomised bench for uart_io_ctrl: a serial-frame monitor and byte queues act
// as the reference, plus a few fixed literal expectations.
module tb_uart_io_ctrl;

  localparam int unsigned CPB   = 4;
  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic [31:0] IO_memAddr_i = '0;
  logic [31:0] IO_memWData_i = '0;
  logic        IO_memWr_i = 1'b0;
  logic        IO_memRd_i = 1'b0;
  logic [31:0] IO_memRData_o;
  logic        rxd_i = 1'b1;
  logic        txd_o;

  always #5 clk = ~clk;

  uart_io_ctrl #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk_i        (clk),
    .reset_i      (reset_i),
    .IO_memAddr_i (IO_memAddr_i),
    .IO_memWData_i(IO_memWData_i),
    .IO_memWr_i   (IO_memWr_i),
    .IO_memRd_i   (IO_memRd_i),
    .IO_memRData_o(IO_memRData_o),
    .rxd_i        (rxd_i),
    .txd_o        (txd_o)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  logic [7:0] tx_exp[$];
  logic [7:0] rx_exp[$];
  bit exp_tx_ovf = 0;
  bit exp_rx_ovr = 0;
  bit exp_ferr = 0;

  bit         mon_active = 0;
  int         mon_k = 0;
  logic [9:0] mon_frame = '1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] reg_addr(input int r);
    logic [31:0] a;
    a = $urandom();
    a[3:2] = 2'(r);
    return a;
  endfunction

  task automatic bus_write(input int r, input logic [31:0] d);
    IO_memAddr_i  = reg_addr(r);
    IO_memWData_i = d;
    IO_memWr_i    = 1'b1;
    tick();
    IO_memWr_i    = 1'b0;
  endtask

  task automatic bus_read(input int r, input bit pop, output logic [31:0] d);
    IO_memAddr_i = reg_addr(r);
    IO_memRd_i   = pop;
    #1;
    d = IO_memRData_o;
    tick();
    IO_memRd_i = 1'b0;
  endtask

  task automatic check_reg(input string name, input int r, input logic [31:0] exp);
    logic [31:0] d;
    bus_read(r, 1'b0, d);
    check(name, d, exp);
  endtask

  function automatic logic [31:0] exp_status(input bit tx_full, input bit tx_empty,
                                             input bit tx_busy);
    logic [31:0] s;
    s = '0;
    s[0] = tx_full;
    s[1] = tx_empty;
    s[2] = (rx_exp.size() != 0);
    s[3] = (rx_exp.size() == DEPTH);
    s[4] = exp_rx_ovr;
    s[5] = exp_ferr;
    s[6] = tx_busy;
    s[7] = exp_tx_ovf;
    return s;
  endfunction

  // Drives one 8N1 frame; stop selects the stop-bit level.
  task automatic send_frame(input logic [7:0] b, input bit stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rxd_i = f[i];
      repeat (CPB) tick();
    end
    rxd_i = 1'b1;
  endtask

  task automatic model_rx_byte(input logic [7:0] b);
    if (rx_exp.size() < DEPTH) rx_exp.push_back(b);
    else exp_rx_ovr = 1;
  endtask

  task automatic wait_tx_idle();
    int n;
    n = 0;
    while ((tx_exp.size() != 0 || mon_active) && n < 3000) begin
      tick();
      n++;
    end
    check("tx_drain_in_time", 32'(n < 3000), 32'd1);
    repeat (3) tick();
  endtask

  task automatic drain_rx();
    logic [31:0] d;
    while (rx_exp.size() != 0) begin
      bus_read(0, 1'b1, d);
      check("rx_data", d, {24'b0, rx_exp.pop_front()});
    end
    bus_read(0, 1'b1, d);
    check("rx_empty_read", d, 32'd0);
  endtask

  // Serial monitor: every TX frame must carry the next expected byte, bit-exact per cycle.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (reset_i) begin
        mon_active = 0;
      end else begin
        if (!mon_active && txd_o == 1'b0) begin
          mon_active = 1;
          mon_k = 0;
          check("tx_frame_expected", 32'(tx_exp.size() != 0), 32'd1);
          if (tx_exp.size() != 0) mon_frame = {1'b1, tx_exp.pop_front(), 1'b0};
          else mon_frame = 10'b1000000000;
        end
        if (mon_active) begin
          check("txd_bit", 32'(txd_o), 32'(mon_frame[mon_k / CPB]));
          mon_k++;
          if (mon_k == 10 * CPB) mon_active = 0;
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic [7:0]  b;
    int          n;

    repeat (3) tick();
    reset_i = 1'b0;
    tick();

    // Reset state
    check("rst_txd", 32'(txd_o), 32'd1);
    check_reg("rst_status", 1, 32'h02);
    check_reg("rst_ctrl", 2, 32'h03);
    check_reg("rst_reg3", 3, 32'h0);
    check_reg("rst_data", 0, 32'h0);

    // TX basic: start bit two edges after the write is presented
    tx_exp.push_back(8'h55);
    bus_write(0, 32'h55);
    check("tx_not_yet", 32'(txd_o), 32'd1);
    tick();
    check("tx_start", 32'(txd_o), 32'd0);
    repeat (CPB) tick();
    check("tx_bit0", 32'(txd_o), 32'd1);
    repeat (CPB) tick();
    check("tx_bit1", 32'(txd_o), 32'd0);
    check_reg("tx_busy_status", 1, 32'h42);
    wait_tx_idle();
    check_reg("tx_done_status", 1, 32'h02);

    // TX overflow: shifter plus FIFO absorb DEPTH+1 bytes
    for (int i = 1; i <= 6; i++) begin
      if (i <= DEPTH + 1) tx_exp.push_back(8'(i));
      bus_write(0, 32'(i));
    end
    exp_tx_ovf = 1;
    check_reg("tx_ovf_full", 1, 32'hC1);
    wait_tx_idle();
    check_reg("tx_ovf_sticky", 1, 32'h82);
    bus_write(1, 32'h80);
    exp_tx_ovf = 0;
    check_reg("tx_ovf_clear", 1, 32'h02);

    // Random TX bursts
    for (int r = 0; r < 4; r++) begin
      n = $urandom_range(1, 7);
      for (int i = 0; i < n; i++) begin
        b = 8'($urandom());
        if (i < DEPTH + 1) tx_exp.push_back(b);
        bus_write(0, {$urandom(), 8'h0} | 32'(b));
      end
      if (n > DEPTH + 1) exp_tx_ovf = 1;
      wait_tx_idle();
      check("tx_rand_status", (dut.IO_memRData_o & 32'h0) | 32'h0, 32'h0);
      check_reg("tx_rand_status", 1, exp_status(0, 1, 0));
      bus_write(1, 32'hFF);
      exp_tx_ovf = 0;
    end

    // tx_en cleared holds the byte in the FIFO
    bus_write(2, 32'h2);
    b = 8'($urandom());
    bus_write(0, 32'(b));
    repeat (20) tick();
    check("txen_hold_txd", 32'(txd_o), 32'd1);
    check_reg("txen_hold_status", 1, 32'h00);
    check_reg("txen_ctrl", 2, 32'h02);
    tx_exp.push_back(b);
    bus_write(2, 32'h3);
    wait_tx_idle();

    // RX basic and pop
    send_frame(8'hA3, 1'b1);
    model_rx_byte(8'hA3);
    repeat (4) tick();
    check_reg("rx_valid_status", 1, 32'h06);
    bus_read(0, 1'b1, d);
    check("rx_a3", d, 32'hA3);
    void'(rx_exp.pop_front());
    check_reg("rx_popped_status", 1, 32'h02);
    check_reg("rx_popped_data", 0, 32'h0);

    // RX overrun with fixed bytes
    for (int i = 0; i < 5; i++) begin
      send_frame(8'h10 + 8'(i), 1'b1);
      model_rx_byte(8'h10 + 8'(i));
    end
    repeat (4) tick();
    check_reg("rx_ovr_status", 1, 32'h1E);
    drain_rx();
    bus_write(1, 32'h10);
    exp_rx_ovr = 0;
    check_reg("rx_ovr_clear", 1, 32'h02);

    // Random RX bursts
    for (int r = 0; r < 4; r++) begin
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) begin
        b = 8'($urandom());
        send_frame(b, 1'b1);
        model_rx_byte(b);
      end
      repeat (4) tick();
      check_reg("rx_rand_status", 1, exp_status(0, 1, 0));
      drain_rx();
      bus_write(1, 32'h10);
      exp_rx_ovr = 0;
    end

    // Frame error then a one-cycle glitch
    send_frame(8'h5A, 1'b0);
    exp_ferr = 1;
    repeat (8) tick();
    check_reg("ferr_status", 1, 32'h22);
    rxd_i = 1'b0;
    tick();
    rxd_i = 1'b1;
    repeat (12) tick();
    check_reg("glitch_status", 1, 32'h22);
    check_reg("glitch_data", 0, 32'h0);
    bus_write(1, 32'h20);
    exp_ferr = 0;
    check_reg("ferr_clear", 1, 32'h02);
    b = 8'($urandom());
    send_frame(b, 1'b1);
    model_rx_byte(b);
    repeat (4) tick();
    drain_rx();

    // rx_en cleared ignores the line
    bus_write(2, 32'h1);
    send_frame(8'($urandom()), 1'b1);
    repeat (4) tick();
    check_reg("rxen_off_status", 1, 32'h02);
    bus_write(2, 32'h3);

    // Reset in the middle of the TX DATA state with two bytes queued
    for (int i = 0; i < 3; i++) begin
      b = 8'($urandom());
      tx_exp.push_back(b);
      bus_write(0, 32'(b));
    end
    repeat (8) tick();
    tx_exp.delete();
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    check("rst_mid_txd", 32'(txd_o), 32'd1);
    check_reg("rst_mid_status", 1, 32'h02);
    repeat (60) tick();
    check("rst_mid_quiet", 32'(txd_o), 32'd1);
    check_reg("rst_mid_ctrl", 2, 32'h03);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
